exc3_bcd_dec: RTL and testbench
===============================

EXC3_BCD_DEC -- requirements
Module: exc3_bcd_dec

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of BCD digits per output word (legal 1..8).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_code  input  4  one Excess-3 coded digit.
REQ-005 SHALL have port in_valid  input  1  in_code/in_last valid this cycle.
REQ-006 SHALL have port in_last  input  1  marks final digit of the current word.
REQ-007 SHALL have port in_ready  output  1  block accepts a digit this cycle.
REQ-008 SHALL have port out_bcd  output  4*NDIG  packed BCD word, right-justified, first-received digit most significant.
REQ-009 SHALL have port out_count  output  $clog2(NDIG+1)  number of digits in out_bcd.
REQ-010 SHALL have port out_err  output  1  at least one invalid code was received in this word.
REQ-011 SHALL have port out_valid  output  1  out_bcd/out_count/out_err valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word.

Function
REQ-013 SHALL decode each digit as bcd = in_code - 3 (modulo 16); valid codes are 0011..1100 only.
REQ-014 SHALL treat codes 0000, 0001, 0010, 1101, 1110, 1111 as invalid: store digit 0000 and set sticky err.
REQ-015 SHALL implement states IDLE (no digits held), ACC (1..NDIG-1 digits held), OUT (word presented).
REQ-016 SHALL assert in_ready in IDLE and ACC and deassert it in OUT.
REQ-017 SHALL accept a digit only on in_valid && in_ready, shifting acc left by 4 and inserting the decoded digit at bits [3:0], incrementing count.
REQ-018 SHALL go IDLE->ACC on an accepted non-final digit; ->OUT on an accepted digit with in_last=1 or when count reaches NDIG.
REQ-019 SHALL enter OUT on the edge after the final accepted digit (latency one clock), with out_valid=1.
REQ-020 SHALL hold out_bcd, out_count, out_err stable while out_valid && !out_ready.
REQ-021 SHALL, on out_valid && out_ready, clear acc, count and err and return to IDLE on the same edge; a concurrent in_valid SHALL NOT be accepted that cycle.
REQ-022 SHALL ignore in_last when in_valid is low; an in_last digit at count NDIG-1 is a single completion, not two.
REQ-023 SHALL drive out_bcd, out_count, out_err to zero whenever out_valid is 0.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, acc=0, count=0, err=0, out_valid=0, in_ready=0 asynchronously.
REQ-025 SHALL raise in_ready on the first clock edge after rst_n deasserts.
REQ-026 SHALL discard any partial or presented word on reset mid-operation; no output word is produced for it.

Structure
REQ-027 SHALL place state encoding (IDLE, ACC, OUT), EXC3_OFFSET=3, EXC3_MIN=4'b0011 and EXC3_MAX=4'b1100 in shared package exc3_pkg.
REQ-028 SHALL instantiate one combinational sub-module exc3_digit_dec (code in; bcd digit and invalid flag out), also reusable by other blocks.
REQ-029 SHALL contain no latches; target 120-400 lines of RTL.

Verification
REQ-030 SHALL verify: codes 0100,0101,0110,0111 back-to-back, out_ready=1 -> out_bcd=16'h1234, out_count=4, out_err=0, out_valid one cycle after fourth accept.
REQ-031 SHALL verify: 1100 then 0011 with in_last=1 -> out_bcd=16'h0090, out_count=2, out_err=0.
REQ-032 SHALL verify: 0100, 0000, 0110, 1111 -> out_bcd=16'h1030, out_err=1; next word 0011 x4 -> out_err=0.
REQ-033 SHALL verify: out_ready held low 5 cycles in OUT -> outputs stable, in_ready=0, in_valid stimulus not consumed.
REQ-034 SHALL verify: rst_n pulsed low after 2 accepted digits -> out_valid never asserts for them; next 4-digit word 0101 x4 -> 16'h2222.
REQ-035 SHALL verify: in_valid high during the out handshake cycle -> digit accepted on the following cycle only.

Source files
------------

// File: rtl/exc3_pkg.sv
// exc3_pkg: shared Excess-3 constants and decoder state encoding
package exc3_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;
  localparam logic [3:0] EXC3_OFFSET = 4'd3;
  localparam logic [3:0] EXC3_MIN = 4'b0011;
  localparam logic [3:0] EXC3_MAX = 4'b1100;
endpackage

// File: rtl/exc3_digit_dec.sv
// exc3_digit_dec: combinational Excess-3 to BCD digit decode with invalid-code flag
module exc3_digit_dec
  import exc3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       bad
);
  always_comb begin
    bad = (code < EXC3_MIN) || (code > EXC3_MAX);
    bcd = bad ? 4'd0 : code - EXC3_OFFSET;
  end
endmodule

// File: rtl/exc3_bcd_dec.sv
// exc3_bcd_dec: accumulates Excess-3 digits into a packed BCD word with valid/ready handshake
module exc3_bcd_dec
  import exc3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  in_code,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [4*NDIG-1:0]           out_bcd,
  output logic [$clog2(NDIG+1)-1:0]   out_count,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int CW = $clog2(NDIG + 1);
  state_t            state, state_n;
  logic [4*NDIG-1:0] acc;
  logic [4*NDIG+3:0] wide;
  logic [CW-1:0]     cnt, cnt_inc;
  logic [3:0]        dig;
  logic              err, bad, accept, done, hs;
  exc3_digit_dec u_dec (.code(in_code), .bcd(dig), .bad(bad));
  assign accept  = in_valid && in_ready;
  assign hs      = out_valid && out_ready;
  assign cnt_inc = cnt + CW'(1);
  assign done    = in_last || (cnt_inc == CW'(NDIG));
  assign wide    = {acc, dig};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == OUT) ? (out_ready ? IDLE : OUT)
            : accept ? (done ? OUT : ACC) : state;
  end
  always_comb begin
    out_valid = (state == OUT);
    out_bcd   = out_valid ? acc : '0;
    out_count = out_valid ? cnt : '0;
    out_err   = out_valid && err;
  end
  // in_ready is registered so it stays low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= (state_n != OUT);
      if (hs) begin
        acc <= '0;
        cnt <= '0;
        err <= 1'b0;
      end else if (accept) begin
        acc <= wide[4*NDIG-1:0];
        cnt <= cnt_inc;
        err <= err | bad;
      end
    end
endmodule

// File: tb/tb_exc3_bcd_dec.sv
// tb_exc3_bcd_dec: directed vectors with a scoreboard queue checked by an output monitor
module tb_exc3_bcd_dec;
  typedef struct packed {
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_code = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_bcd;
  logic [2:0]  out_count;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  exc3_bcd_dec #(.NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_bcd(out_bcd),
    .out_count(out_count), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", out_bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_bcd", 32'(out_bcd), 32'(e.bcd));
        chk("mon_count", 32'(out_count), 32'(e.cnt));
        chk("mon_err", 32'(out_err), 32'(e.err));
      end
    end
  end
  task automatic send(input logic [3:0] code, input logic last);
    logic ok;
    int   n;
    in_code  = code;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);
    // four digits back-to-back, completion on count
    sb.push_back('{16'h1234, 3'd4, 1'b0});
    send(4'b0100, 1'b0);
    send(4'b0101, 1'b0);
    send(4'b0110, 1'b0);
    chk("w1_not_yet_valid", 32'(out_valid), 32'd0);
    send(4'b0111, 1'b0);
    idle();
    chk("w1_latency_valid", 32'(out_valid), 32'd1);
    chk("w1_in_ready_out", 32'(in_ready), 32'd0);
    // short word with in_last
    sb.push_back('{16'h0090, 3'd2, 1'b0});
    send(4'b1100, 1'b0);
    send(4'b0011, 1'b1);
    idle();
    // invalid codes set sticky err, next word clears it
    sb.push_back('{16'h1030, 3'd4, 1'b1});
    sb.push_back('{16'h0000, 3'd4, 1'b0});
    send(4'b0100, 1'b0);
    send(4'b0000, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b1111, 1'b0);
    repeat (4) send(4'b0011, 1'b0);
    idle();
    // stall in OUT with pending input, then handshake with in_valid held high
    sb.push_back('{16'h0345, 3'd3, 1'b0});
    sb.push_back('{16'h0006, 3'd1, 1'b0});
    send(4'b0110, 1'b0);
    send(4'b0111, 1'b0);
    out_ready = 1'b0;
    send(4'b1000, 1'b1);
    in_code  = 4'b1001;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bcd", 32'(out_bcd), 32'h0345);
      chk("stall_count", 32'(out_count), 32'd3);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post_hs_valid", 32'(out_valid), 32'd1);
    chk("post_hs_count", 32'(out_count), 32'd1);
    idle();
    @(posedge clk);
    #1;
    // reset mid-word discards the partial digits
    send(4'b0101, 1'b0);
    send(4'b0101, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_word", 32'(out_valid), 32'd0);
    end
    sb.push_back('{16'h2222, 3'd4, 1'b0});
    repeat (4) send(4'b0101, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
